// File: rtl/nco_bank_if.sv
// Configuration bus for the NCO bank: shadow-register writes plus the commit strobe.
interface nco_bank_if #(
    parameter int CH    = 4,
    parameter int ACC_W = 28
) ();
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_sel;
    logic [ACC_W-1:0] cfg_data;
    logic             commit;

    modport master (
        output cfg_valid, cfg_ch, cfg_sel, cfg_data, commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_sel, cfg_data, commit,
        output cfg_ready
    );
endinterface

// File: rtl/nco_bank.sv
// Multi-channel NCO bank: double-buffered frequency/phase registers, per-channel
// phase accumulators and a three-stage quarter-wave sine pipeline.
module nco_bank #(
    parameter int CH     = 4,
    parameter int ACC_W  = 28,
    parameter int OUT_W  = 10,
    parameter int LUT_AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    nco_bank_if.slave           cfg,
    input  logic                sync_clr,
    input  logic [CH-1:0]       ch_en,
    output logic [CH*OUT_W-1:0] dout,
    output logic                dout_valid
);

    localparam int TOP_W = LUT_AW + 2;
    localparam int LUT_N = 2 ** LUT_AW;
    localparam int AMP   = 2 ** (OUT_W - 1) - 1;
    localparam int FRAC  = 30;

    // Fixed-point Taylor series for AMP*sin(2*pi*(idx+0.5)/2^(LUT_AW+2)), rounded.
    // The angle stays below pi/2, so seven correction terms are ample in Q30.
    function automatic logic [OUT_W-2:0] lut_val(input int idx);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (longint'(2 * idx + 1) * 64'sd3373259426) >>> TOP_W;
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int n = 1; n < 8; n++) begin
            term = -(((term * x2) >>> FRAC) / longint'(2 * n * (2 * n + 1)));
            sum  = sum + term;
        end
        return (OUT_W-1)'((sum * AMP + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

    logic [OUT_W-2:0] lut_rom [LUT_N];

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam logic [OUT_W-2:0] ENTRY = lut_val(gi);
        assign lut_rom[gi] = ENTRY;
    end

    logic [ACC_W-1:0]  freq_sh   [CH];
    logic [ACC_W-1:0]  phase_sh  [CH];
    logic [ACC_W-1:0]  freq_act  [CH];
    logic [ACC_W-1:0]  phase_act [CH];
    logic [ACC_W-1:0]  freq_nx   [CH];
    logic [ACC_W-1:0]  phase_nx  [CH];
    logic [ACC_W-1:0]  acc       [CH];
    logic [TOP_W-1:0]  p_top     [CH];
    logic [LUT_AW-1:0] s1_addr   [CH];
    logic              s1_neg    [CH];
    logic              s1_en     [CH];
    logic [OUT_W-2:0]  s2_mag    [CH];
    logic              s2_neg    [CH];
    logic              s2_en     [CH];
    logic [1:0]        fill;
    logic              wr_en;

    assign wr_en = cfg.cfg_valid & cfg.cfg_ready;

    // Shadow contents after this edge's write; commit copies these so a same-edge write is included.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            freq_nx[k]  = freq_sh[k];
            phase_nx[k] = phase_sh[k];
            if (wr_en && int'(cfg.cfg_ch) == k) begin
                if (cfg.cfg_sel) begin
                    phase_nx[k] = cfg.cfg_data;
                end else begin
                    freq_nx[k] = cfg.cfg_data;
                end
            end
        end
    end

    // Shadow and active register banks; writes are refused for one cycle after a commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                freq_sh[k]   <= '0;
                phase_sh[k]  <= '0;
                freq_act[k]  <= '0;
                phase_act[k] <= '0;
            end
            cfg.cfg_ready <= 1'b1;
        end else begin
            for (int k = 0; k < CH; k++) begin
                freq_sh[k]  <= freq_nx[k];
                phase_sh[k] <= phase_nx[k];
                if (cfg.commit) begin
                    freq_act[k]  <= freq_nx[k];
                    phase_act[k] <= phase_nx[k];
                end
            end
            cfg.cfg_ready <= ~cfg.commit;
        end
    end

    // Phase accumulators: sync_clr zeroes every channel, otherwise enabled channels advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (sync_clr) begin
                    acc[k] <= '0;
                end else if (ch_en[k]) begin
                    acc[k] <= acc[k] + freq_act[k];
                end
            end
        end
    end

    // Top bits of the offset phase; the cast keeps the sum modulo a full turn.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            p_top[k] = TOP_W'((acc[k] + phase_act[k]) >> (ACC_W - TOP_W));
        end
    end

    // Three-stage sine pipeline: quadrant fold, table read, sign restore and enable gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                s1_addr[k] <= '0;
                s1_neg[k]  <= 1'b0;
                s1_en[k]   <= 1'b0;
                s2_mag[k]  <= '0;
                s2_neg[k]  <= 1'b0;
                s2_en[k]   <= 1'b0;
            end
            dout <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                s1_addr[k] <= p_top[k][TOP_W-2] ? ~p_top[k][LUT_AW-1:0] : p_top[k][LUT_AW-1:0];
                s1_neg[k]  <= p_top[k][TOP_W-1];
                s1_en[k]   <= ch_en[k];
                s2_mag[k]  <= lut_rom[s1_addr[k]];
                s2_neg[k]  <= s1_neg[k];
                s2_en[k]   <= s1_en[k];
                dout[k*OUT_W +: OUT_W] <= s2_en[k]
                    ? (s2_neg[k] ? -{1'b0, s2_mag[k]} : {1'b0, s2_mag[k]})
                    : '0;
            end
        end
    end

    // Marks the pipeline as filled on the third edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill       <= '0;
            dout_valid <= 1'b0;
        end else begin
            fill       <= {fill[0], 1'b1};
            dout_valid <= fill[1];
        end
    end

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank: directed phase vectors plus multi-cycle sequences
// for commit timing, frequency behaviour, channel enable and mid-run reset.
module tb_nco_bank;

    localparam int CH    = 4;
    localparam int ACC_W = 28;
    localparam int OUT_W = 10;
    localparam logic [ACC_W-1:0] FSTEP = 28'd5368709;
    localparam logic [ACC_W-1:0] NYQ   = 28'd134217728;

    logic                clk = 1'b0;
    logic                rst;
    logic                sync_clr;
    logic [CH-1:0]       ch_en;
    logic [CH*OUT_W-1:0] dout;
    logic                dout_valid;

    int errors = 0;
    int checks = 0;

    nco_bank_if #(.CH(CH), .ACC_W(ACC_W)) cfg_if ();

    nco_bank #(
        .CH(CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .LUT_AW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfg_if),
        .sync_clr(sync_clr),
        .ch_en(ch_en),
        .dout(dout),
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       ch;
        logic [ACC_W-1:0] phase;
        bit               same_edge;
        int               expected;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    function automatic int chan_out(input int k);
        return int'($signed(dout[k*OUT_W +: OUT_W]));
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cfg_write(input int ch, input bit sel, input logic [ACC_W-1:0] data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_sel   = sel;
        cfg_if.cfg_data  = data;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Writes a phase word, commits it (same edge or next edge) and lets the pipeline fill.
    task automatic applyStimulus(input vec_t v);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = v.ch;
        cfg_if.cfg_sel   = 1'b1;
        cfg_if.cfg_data  = v.phase;
        cfg_if.commit    = v.same_edge;
        tick();
        cfg_if.cfg_valid = 1'b0;
        if (!v.same_edge) begin
            cfg_if.commit = 1'b1;
            tick();
        end
        cfg_if.commit = 1'b0;
        wait_cycles(3);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int changes0;
        int changes3;
        bit neg0;
        bit neg3;

        // Frequency 0, acc 0: only the phase word selects the table entry.
        vecs[0]  = '{2'd0, 28'd0,         1'b1,    2};
        vecs[1]  = '{2'd1, 28'd67108864,  1'b0,  511};
        vecs[2]  = '{2'd2, 28'd134217728, 1'b1,   -2};
        vecs[3]  = '{2'd3, 28'd201326592, 1'b0, -511};
        vecs[4]  = '{2'd0, 28'd33554432,  1'b1,  362};
        vecs[5]  = '{2'd1, 28'd100663296, 1'b0,  360};
        vecs[6]  = '{2'd2, 28'd16777216,  1'b1,  197};
        vecs[7]  = '{2'd3, 28'd150994944, 1'b0, -197};
        vecs[8]  = '{2'd0, 28'd201064448, 1'b1, -511};
        vecs[9]  = '{2'd1, 28'd262143,    1'b0,    2};
        vecs[10] = '{2'd2, 28'd268435455, 1'b1,   -2};

        rst              = 1'b0;
        sync_clr         = 1'b0;
        ch_en            = 4'hF;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_sel   = 1'b0;
        cfg_if.cfg_data  = '0;
        cfg_if.commit    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dout", longint'(dout), 0);
        checkOutput("reset_valid", dout_valid, 0);
        checkOutput("reset_ready", cfg_if.cfg_ready, 1);

        rst = 1'b1;
        tick();
        tick();
        checkOutput("valid_edge2", dout_valid, 0);
        tick();
        checkOutput("valid_edge3", dout_valid, 1);
        for (int k = 0; k < CH; k++) begin
            checkOutput($sformatf("post_reset_ch%0d", k), chan_out(k), 2);
        end

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ch%0d", i, vecs[i].ch), chan_out(int'(vecs[i].ch)), vecs[i].expected);
        end

        // Same-edge write joins the commit; ready drops for one cycle and a held write lands after.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_sel   = 1'b1;
        cfg_if.cfg_data  = 28'd67108864;
        cfg_if.commit    = 1'b1;
        tick();
        checkOutput("ready_after_commit", cfg_if.cfg_ready, 0);
        cfg_if.commit   = 1'b0;
        cfg_if.cfg_ch   = 2'd1;
        tick();
        checkOutput("ready_restored", cfg_if.cfg_ready, 1);
        cfg_if.cfg_ch   = 2'd0;
        cfg_if.cfg_data = NYQ;
        tick();
        cfg_if.cfg_valid = 1'b0;
        tick();
        checkOutput("bypass_commit_ch0", chan_out(0), 511);
        cfg_if.commit = 1'b1;
        tick();
        cfg_if.commit = 1'b0;
        wait_cycles(3);
        checkOutput("held_write_ch0", chan_out(0), -2);
        checkOutput("dropped_write_ch1", chan_out(1), 2);

        // Channel k runs at (k+1)*2^28/50 from phase 0; shadow-only writes must not disturb it.
        for (int k = 0; k < CH; k++) begin
            cfg_write(k, 1'b1, '0);
            cfg_write(k, 1'b0, ACC_W'((k + 1) * int'(FSTEP)));
        end
        cfg_if.commit = 1'b1;
        sync_clr      = 1'b1;
        tick();
        cfg_if.commit = 1'b0;
        sync_clr      = 1'b0;
        wait_cycles(2);
        changes0 = 0;
        changes3 = 0;
        neg0 = 1'b0;
        neg3 = 1'b0;
        for (int m = 3; m <= 102; m++) begin
            tick();
            if (m == 3) begin
                checkOutput("t1_first_ch0", chan_out(0), 2);
                checkOutput("t1_first_ch3", chan_out(3), 2);
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_ch    = 2'd0;
                cfg_if.cfg_sel   = 1'b0;
                cfg_if.cfg_data  = NYQ;
            end else if (m == 4) begin
                cfg_if.cfg_ch = 2'd1;
            end else if (m == 5) begin
                cfg_if.cfg_valid = 1'b0;
            end
            if (m > 3) begin
                if ((chan_out(0) < 0) != neg0) changes0++;
                if ((chan_out(3) < 0) != neg3) changes3++;
            end
            neg0 = chan_out(0) < 0;
            neg3 = chan_out(3) < 0;
        end
        checkOutput("t1_ch0_sign_changes", changes0, 3);
        checkOutput("t1_ch3_sign_changes", changes3, 15);

        // Nyquist on ch0/ch1 with commit and sync_clr together, then ch1 disable/re-enable.
        cfg_if.commit = 1'b1;
        sync_clr      = 1'b1;
        tick();
        cfg_if.commit = 1'b0;
        sync_clr      = 1'b0;
        wait_cycles(2);
        for (int m = 3; m <= 6; m++) begin
            tick();
            checkOutput($sformatf("nyq_ch0_m%0d", m), chan_out(0), (m % 2 == 1) ? 2 : -2);
            if (m == 3) checkOutput("nyq_ch1_m3", chan_out(1), 2);
        end
        ch_en = 4'b1101;
        wait_cycles(3);
        checkOutput("t5_ch1_disabled", chan_out(1), 0);
        ch_en = 4'hF;
        wait_cycles(2);
        checkOutput("t5_ch1_still_zero", chan_out(1), 0);
        tick();
        checkOutput("t5_ch1_resume", chan_out(1), 2);
        checkOutput("t5_ch0_running", chan_out(0), -2);
        tick();
        checkOutput("t5_ch1_resume_next", chan_out(1), -2);
        checkOutput("valid_stays_high", dout_valid, 1);

        // Reset pulse mid-run clears outputs at once; refill takes three edges.
        rst = 1'b0;
        #1;
        checkOutput("midreset_dout", longint'(dout), 0);
        checkOutput("midreset_valid", dout_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rerelease_valid_edge2", dout_valid, 0);
        tick();
        checkOutput("rerelease_valid_edge3", dout_valid, 1);
        for (int k = 0; k < CH; k++) begin
            checkOutput($sformatf("rerelease_ch%0d", k), chan_out(k), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
